instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 137 +++++++++++++
 tb/tb_instruction_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Pipelined instruction fetch with a 2-entry skid buffer in
//               front of a 1-cycle-latency ROM. Optional performance counters
//               are enabled by defining FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [2:0] c_depth = 3'(BUF_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] fifo_word_q [2];
    logic [31:0] fifo_word_d [2];
    logic [1:0]  count_q, count_d;

    logic        w_pop;
    logic        w_issue;
    logic        w_push;
    logic [2:0]  w_occ;
    logic [1:0]  w_base;
    logic [31:0] w_target;

    assign instr_valid = (count_q != 2'd0) & ~reset;
    assign w_pop       = instr_valid & instr_ready;
    // Entries that will exist once the in-flight word lands, net of this pop.
    assign w_occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_issue     = ~redirect & (w_occ < c_depth);
    assign w_push      = inflight_q & ~redirect;
    assign w_target    = redirect_pc & 32'hFFFF_FFFC;

    assign rom_address = reset ? RESET_PC : pc_q;
    assign instr       = instr_valid ? fifo_word_q[0] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc_q[0]   : 32'h0;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_word_d   = fifo_word_q;
        count_d       = count_q;
        w_base        = count_q - {1'b0, w_pop};
        if (redirect) begin
            pc_d    = w_target;
            count_d = 2'd0;
        end else begin
            // Head lives in slot 0; a pop shifts slot 1 down before any push.
            if (w_pop) begin
                fifo_pc_d[0]   = fifo_pc_q[1];
                fifo_word_d[0] = fifo_word_q[1];
            end
            if (w_push) begin
                if (w_base == 2'd0) begin
                    fifo_pc_d[0]   = inflight_pc_q;
                    fifo_word_d[0] = rom_data;
                end else begin
                    fifo_pc_d[1]   = inflight_pc_q;
                    fifo_word_d[1] = rom_data;
                end
            end
            count_d = w_base + {1'b0, w_push};
            if (w_issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_word_q <= fifo_word_d;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (w_pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (instr_valid & ~instr_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch; expected instruction
//               stream derived from fetch-address sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    instruction_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_address);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] stream_pc;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          epoch_start = 0;
    logic        prev_redirect;
    logic [31:0] prev_target;
    int          model_fetch = 0;
    int          model_stall = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle; the stream model restarts on reset or after a redirect.
    task automatic step(input logic rst, input logic rdr, input logic [31:0] tgt, input logic rdy);
        @(posedge clk);
        #1;
        cyc++;
        if (prev_redirect) begin
            q.delete();
            stream_pc   = prev_target & 32'hFFFF_FFFC;
            epoch_start = cyc;
        end
        if (rst) begin
            q.delete();
            stream_pc = RST_PC;
        end else if (reset) begin
            epoch_start = cyc;
        end
        reset         = rst;
        redirect      = rdr;
        redirect_pc   = tgt;
        instr_ready   = rdy;
        prev_redirect = rdr & ~rst;
        prev_target   = tgt;
        while (q.size() < 4) begin
            q.push_back({stream_pc, rom_word(stream_pc)});
            stream_pc = stream_pc + 32'd4;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("rst_valid", {31'b0, instr_valid}, 32'd0);
            check("rst_instr", instr, 32'd0);
            check("rst_pc", instr_pc, 32'd0);
            check("rst_addr", rom_address, RST_PC);
            model_fetch = 0;
            model_stall = 0;
            prev_hold   = 1'b0;
        end else begin
            check("valid_timing", {31'b0, instr_valid}, {31'b0, (cyc >= epoch_start + 2)});
            if (!instr_valid) begin
                check("idle_instr", instr, 32'd0);
                check("idle_pc", instr_pc, 32'd0);
            end
            if (prev_hold) begin
                check("hold_pc", instr_pc, prev_pc);
                check("hold_instr", instr, prev_instr);
            end
            if (instr_valid && instr_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got pc %h want no delivery", instr_pc);
                end else begin
                    e = q.pop_front();
                    check("sb_pc", instr_pc, e.pc);
                    check("sb_instr", instr, e.word);
                end
                model_fetch++;
            end
            if (instr_valid && !instr_ready) model_stall++;
            check("addr_align", {30'b0, rom_address[1:0]}, 32'd0);
            prev_hold  = instr_valid & ~instr_ready & ~redirect;
            prev_pc    = instr_pc;
            prev_instr = instr;
        end
    end

    initial begin
        logic found;
        int   r;
        logic rst_r, rdr_r, rdy_r;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        prev_redirect = 1'b0; prev_target = 32'h0; stream_pc = RST_PC;

        // Straight-line stream from reset
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Consumer stall right as the first instruction appears
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            check("stall_addr", rom_address, RST_PC + 32'd8);
            check("stall_head_pc", instr_pc, RST_PC);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Unaligned redirect in a steady stream
        step(1'b0, 1'b1, 32'h0000_0043, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect in the same cycle pc 8 is accepted
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (instr_valid && instr_pc == RST_PC + 32'd8) begin
                redirect = 1'b1; redirect_pc = 32'h0000_0100;
                prev_redirect = 1'b1; prev_target = 32'h0000_0100;
                found = 1'b1;
            end
        end
        check("pc8_seen", {31'b0, found}, 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset while the buffer is full
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r     = $urandom_range(0, 99);
            rst_r = (r < 2);
            rdr_r = (r >= 2) && (r < 8);
            rdy_r = ($urandom_range(0, 3) != 0);
            step(rst_r, rdr_r, $urandom, rdy_r);
        end

`ifdef FETCH_PERF_EN
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("perf_fetch_model", fetch_count, model_fetch);
        check("perf_stall_model", stall_count, model_stall);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 32'h0, !(i == 2 || i == 5 || i == 8));
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("perf_fetch", fetch_count, 32'd10);
        check("perf_stall", stall_count, 32'd3);
`endif
        step(1'b0, 1'b0, 32'h0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
